decompression_video_unpack: RTL

//  Inverse of the 2:1 pixel packer: accepts one packed word (two pixels) per beat and emits one

---
 rtl/decompression_video_unpack_pkg.sv | 13 +
 rtl/decompression_video_unpack_pos_counter.sv | 50 +++++
 rtl/decompression_video_unpack.sv | 88 ++++++++
 3 files changed

// File: rtl/decompression_video_unpack_pkg.sv
// Shared types and defaults for the packed-video unpacker and its position counter.
package decompression_video_unpack_pkg;

  typedef enum logic [1:0] {
    StEmpty,
    StFirst,
    StSecond
  } unpack_state_e;

  localparam int unsigned HActiveDefault = 1920;
  localparam int unsigned VActiveDefault = 1080;

endpackage

// File: rtl/decompression_video_unpack_pos_counter.sv
// Pixel/line position counter: advances one column per pixel beat, wraps at the active
// frame edges, and can be forced to (0,0) at start of frame.
module decompression_video_unpack_pos_counter #(
  parameter int unsigned PIX_CW   = 11,
  parameter int unsigned LINE_CW  = 11,
  parameter int unsigned H_ACTIVE = 1920,
  parameter int unsigned V_ACTIVE = 1080
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               advance_i,
  input  logic               clear_i,
  output logic [PIX_CW-1:0]  pix_o,
  output logic [LINE_CW-1:0] lines_o
);

  logic [PIX_CW-1:0]  pix_q, pix_d;
  logic [LINE_CW-1:0] lines_q, lines_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pix_q   <= '0;
      lines_q <= '0;
    end else begin
      pix_q   <= pix_d;
      lines_q <= lines_d;
    end
  end

  // Clear wins over advance so a start-of-frame word restarts at (0,0) regardless of wrap.
  always_comb begin
    pix_d   = pix_q;
    lines_d = lines_q;
    if (clear_i) begin
      pix_d   = '0;
      lines_d = '0;
    end else if (advance_i) begin
      if (pix_q == PIX_CW'(H_ACTIVE - 1)) begin
        pix_d   = '0;
        lines_d = (lines_q == LINE_CW'(V_ACTIVE - 1)) ? '0 : lines_q + LINE_CW'(1);
      end else begin
        pix_d = pix_q + PIX_CW'(1);
      end
    end
  end

  assign pix_o   = pix_q;
  assign lines_o = lines_q;

endmodule

// File: rtl/decompression_video_unpack.sv
// 1:2 pixel unpacker with pix/lines position regeneration at one pixel per clock.
// Define UNPACK_SWAP_EN to emit the high-half pixel of each word first.
module decompression_video_unpack
  import decompression_video_unpack_pkg::*;
#(
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned PIX_CW   = 11,
  parameter int unsigned LINE_CW  = 11,
  parameter int unsigned H_ACTIVE = HActiveDefault,
  parameter int unsigned V_ACTIVE = VActiveDefault
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               enable,
  input  logic [2*PIX_W-1:0] in_pix,
  input  logic               in_sof,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [PIX_W-1:0]   out_pix,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIX_CW-1:0]  pix,
  output logic [LINE_CW-1:0] lines,
  output logic               out_sof
);

`ifdef UNPACK_SWAP_EN
  localparam bit SwapEn = 1'b1;
`else
  localparam bit SwapEn = 1'b0;
`endif

  unpack_state_e      state_q, state_d;
  logic [2*PIX_W-1:0] hold_q, hold_d;
  logic               accept, beat;
  logic [PIX_W-1:0]   first_pix, second_pix;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty:  if (accept) state_d = StFirst;
      StFirst:  if (beat) state_d = StSecond;
      StSecond: if (beat) state_d = accept ? StFirst : StEmpty;
      default:  state_d = StEmpty;
    endcase
  end

  assign first_pix  = SwapEn ? hold_q[2*PIX_W-1:PIX_W] : hold_q[PIX_W-1:0];
  assign second_pix = SwapEn ? hold_q[PIX_W-1:0] : hold_q[2*PIX_W-1:PIX_W];

  // in_ready is also held low while reset is asserted so nothing is taken during reset.
  always_comb begin
    in_ready  = enable & ~rst &
                ((state_q == StEmpty) | ((state_q == StSecond) & out_ready));
    out_valid = enable & (state_q != StEmpty);
    out_pix   = (state_q == StSecond) ? second_pix : first_pix;
    accept    = in_valid & in_ready;
    beat      = out_valid & out_ready;
    hold_d    = accept ? in_pix : hold_q;
  end

  decompression_video_unpack_pos_counter #(
    .PIX_CW   (PIX_CW),
    .LINE_CW  (LINE_CW),
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_pos_counter (
    .clk_i     (clk_in),
    .rst_i     (rst),
    .advance_i (beat),
    .clear_i   (accept & in_sof),
    .pix_o     (pix),
    .lines_o   (lines)
  );

  assign out_sof = out_valid & (pix == '0) & (lines == '0);

endmodule
